sieve_engine: RTL and testbench
===============================

// Module: sieve_engine
// PURPOSE
//   Parametrised Sieve of Eratosthenes engine. Finds all primes in 2..limit for a runtime limit.
//   Streams each prime over a valid/ready port and stores the first LIST_DEPTH primes in an
//   internal list with a random-read port. Sits between the debounced button/start logic and the
//   LCD text formatter. Replaces the fixed-size sieve FSM in the top level.
// PARAMETERS
//   ADDR_W     10   value width; sieve bit memory has 2**ADDR_W entries; max limit 2**ADDR_W-1
//   LIST_DEPTH 256  prime list entries
//   IDX_W      8    list index width; 2**IDX_W >= LIST_DEPTH
// PORTS
//   clk          in   1         single clock, rising edge
//   rst          in   1         asynchronous, active-low reset
//   start        in   1         1-cycle pulse; accepted only in IDLE or DONE
//   limit        in   ADDR_W    upper bound, sampled when start is accepted
//   busy         out  1         high from the cycle after accept until DONE
//   done         out  1         high in DONE; held until the next accepted start
//   out_valid    out  1         a prime is presented on out_data
//   out_ready    in   1         consumer accepts; transfer = out_valid & out_ready
//   out_data     out  ADDR_W    prime value
//   prime_count  out  IDX_W+1   number of list entries written (saturates at LIST_DEPTH)
//   overflow     out  1         more primes found than LIST_DEPTH
//   rd_idx       in   IDX_W     list read index
//   rd_data      out  ADDR_W    list[rd_idx], registered, 1-cycle latency; 0 if rd_idx>=prime_count
// BEHAVIOUR
//   Reset (rst=0, async): state IDLE; busy, done, out_valid, overflow, prime_count, rd_data,
//     out_data = 0. Sieve memory and list contents are not cleared.
//   Sieve memory: 1 bit per entry, synchronous write, registered read (data valid next cycle).
//   Registers: L = latched limit; p = candidate; m = multiple; c = collect index.
//   States:
//     IDLE/DONE : on start -> latch L. If L<2: prime_count=0, overflow=0, go to DONE next cycle.
//                 Otherwise clear prime_count and overflow and go to INIT with m=0.
//     INIT      : write 1 to addr m, m+=1, one per cycle; after m==L -> p=2 -> SCAN_RD.
//     SCAN_RD   : read addr p -> SCAN_CHK.
//     SCAN_CHK  : if p*p > L (product in 2*ADDR_W bits) -> c=2 -> COL_RD.
//                 else if bit==1 -> m=p*p -> MARK.
//                 else p+=1 -> SCAN_RD.
//     MARK      : write 0 to addr m, m+=p (ADDR_W+1 bits, no wrap); when next m > L
//                 -> p+=1 -> SCAN_RD.
//     COL_RD    : read addr c -> COL_CHK.
//     COL_CHK   : if bit==1 -> assert out_valid, out_data=c; if prime_count<LIST_DEPTH then
//                 list[prime_count]<=c and prime_count+=1, else overflow<=1 -> COL_WAIT.
//                 If bit==0: c==L -> DONE, else c+=1 -> COL_RD.
//     COL_WAIT  : hold out_valid/out_data stable until out_ready. On transfer, out_valid=0 next
//                 cycle; c==L -> DONE, else c+=1 -> COL_RD.
//   out_valid is never dropped without a transfer. The stream always delivers every prime
//     in ascending order, including those beyond LIST_DEPTH.
//   start while busy is ignored. The list read port is usable in any state.
//   Mid-run reset aborts immediately. A subsequent start gives a correct result, because INIT
//     rewrites all of 0..L.
//   Limit = 2**ADDR_W-1 must not wrap m or c: both counters are ADDR_W+1 bits.
// TESTING
//   1. limit=30, out_ready=1 -> stream 2,3,5,7,11,13,17,19,23,29; prime_count=10; overflow=0;
//      done=1.
//   2. limit=1 and limit=0 -> done within 2 cycles of start; prime_count=0; no out_valid.
//   3. limit=1023 (defaults) -> 172 primes streamed; last=1021; prime_count=172;
//      rd_idx=171 -> rd_data=1021 next cycle; rd_idx=200 -> 0.
//   4. LIST_DEPTH=16, limit=1023 -> prime_count=16, overflow=1, list[15]=53; stream still
//      carries 172 primes.
//   5. limit=100, out_ready random 30% -> 25 primes, no drops or duplicates; out_data stable
//      while stalled.
//   6. Assert rst=0 during MARK (limit=500), release, start limit=30 -> same result as test 1;
//      start pulse during busy -> ignored.

Source files
------------

// File: rtl/sieve_engine.sv
// Sieve of Eratosthenes engine: marks composites up to a runtime limit, then streams every
// prime over valid/ready and keeps the first LIST_DEPTH primes in a randomly readable list.
module sieve_engine #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned LIST_DEPTH = 256,
    parameter int unsigned IDX_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] limit,
    output logic              busy,
    output logic              done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_data,
    output logic [IDX_W:0]    prime_count,
    output logic              overflow,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [ADDR_W-1:0] rd_data
);

    localparam int unsigned MEM_DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W     = ADDR_W + 1;
    localparam int unsigned PROD_W    = 2 * ADDR_W;
    localparam int unsigned PC_W      = IDX_W + 1;

    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_SCAN_RD, S_SCAN_CHK, S_MARK,
        S_COL_RD, S_COL_CHK, S_COL_WAIT, S_DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] lim;
    logic [ADDR_W-1:0] p;
    logic [CNT_W-1:0]  m;
    logic [CNT_W-1:0]  c;
    logic              bit_q;

    logic              sieve_mem [MEM_DEPTH];
    logic [ADDR_W-1:0] list_mem  [LIST_DEPTH];

    logic              accept;
    logic [PROD_W-1:0] p_sq;
    logic [CNT_W-1:0]  m_step;
    logic [CNT_W-1:0]  lim_ext;
    logic              list_room;
    logic [ADDR_W-1:0] rd_addr;

    assign accept    = start && (state == S_IDLE || state == S_DONE);
    assign p_sq      = PROD_W'(p) * PROD_W'(p);
    assign m_step    = m + CNT_W'(p);
    assign lim_ext   = CNT_W'(lim);
    assign list_room = prime_count < PC_W'(LIST_DEPTH);
    assign rd_addr   = (state == S_SCAN_RD) ? p : c[ADDR_W-1:0];

    // Sieve bit memory and prime list: plain RAMs, never cleared by reset.
    always_ff @(posedge clk) begin
        if (state == S_INIT) begin
            sieve_mem[m[ADDR_W-1:0]] <= 1'b1;
        end else if (state == S_MARK) begin
            sieve_mem[m[ADDR_W-1:0]] <= 1'b0;
        end
        bit_q <= sieve_mem[rd_addr];
        if (state == S_COL_CHK && bit_q && list_room) begin
            list_mem[prime_count[IDX_W-1:0]] <= c[ADDR_W-1:0];
        end
    end

    // Registered list read port; entries beyond prime_count read as zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (PC_W'(rd_idx) < prime_count) begin
            rd_data <= list_mem[rd_idx];
        end else begin
            rd_data <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            lim         <= '0;
            p           <= '0;
            m           <= '0;
            c           <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            prime_count <= '0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        lim         <= limit;
                        prime_count <= '0;
                        overflow    <= 1'b0;
                        if (limit < ADDR_W'(2)) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= S_INIT;
                            m     <= '0;
                            done  <= 1'b0;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_INIT: begin
                    if (m == lim_ext) begin
                        p     <= ADDR_W'(2);
                        state <= S_SCAN_RD;
                    end else begin
                        m <= m + CNT_W'(1);
                    end
                end
                S_SCAN_RD: state <= S_SCAN_CHK;
                S_SCAN_CHK: begin
                    if (p_sq > PROD_W'(lim)) begin
                        c     <= CNT_W'(2);
                        state <= S_COL_RD;
                    end else if (bit_q) begin
                        m     <= p_sq[CNT_W-1:0];
                        state <= S_MARK;
                    end else begin
                        p     <= p + ADDR_W'(1);
                        state <= S_SCAN_RD;
                    end
                end
                S_MARK: begin
                    m <= m_step;
                    if (m_step > lim_ext) begin
                        p     <= p + ADDR_W'(1);
                        state <= S_SCAN_RD;
                    end
                end
                S_COL_RD: state <= S_COL_CHK;
                S_COL_CHK: begin
                    if (bit_q) begin
                        out_valid <= 1'b1;
                        out_data  <= c[ADDR_W-1:0];
                        if (list_room) begin
                            prime_count <= prime_count + PC_W'(1);
                        end else begin
                            overflow <= 1'b1;
                        end
                        state <= S_COL_WAIT;
                    end else if (c == lim_ext) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        c     <= c + CNT_W'(1);
                        state <= S_COL_RD;
                    end
                end
                S_COL_WAIT: begin
                    // Hold the presented prime until the consumer takes it.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (c == lim_ext) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            c     <= c + CNT_W'(1);
                            state <= S_COL_RD;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sieve_engine.sv
// Bench for sieve_engine: table-driven limits, random limits and back-pressure, list reads,
// mid-run reset. A second instance with a 16-entry list runs in lockstep for overflow checks.
module tb_sieve_engine;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned IDX_W  = 8;
    localparam int          BUDGET = 20000;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] limit;
    logic              out_ready;
    logic [IDX_W-1:0]  rd_idx;

    logic              a_busy, a_done, a_valid, a_ovf;
    logic [ADDR_W-1:0] a_data, a_rd;
    logic [IDX_W:0]    a_cnt;
    logic              b_busy, b_done, b_valid, b_ovf;
    logic [ADDR_W-1:0] b_data, b_rd;
    logic [IDX_W:0]    b_cnt;

    always #5 clk = ~clk;

    sieve_engine dut (
        .clk(clk), .rst(rst), .start(start), .limit(limit),
        .busy(a_busy), .done(a_done), .out_valid(a_valid), .out_ready(out_ready),
        .out_data(a_data), .prime_count(a_cnt), .overflow(a_ovf),
        .rd_idx(rd_idx), .rd_data(a_rd)
    );

    sieve_engine #(.LIST_DEPTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start), .limit(limit),
        .busy(b_busy), .done(b_done), .out_valid(b_valid), .out_ready(out_ready),
        .out_data(b_data), .prime_count(b_cnt), .overflow(b_ovf),
        .rd_idx(rd_idx), .rd_data(b_rd)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic bit is_prime(input int n);
        if (n < 2) return 1'b0;
        for (int d = 2; d * d <= n; d++) begin
            if (n % d == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    typedef struct {
        int lim;
        int ready_pct;
        bit inject;
        int exp_count;
        int exp_last;
    } vec_t;

    // One full run; expectations come from trial division and, when given, table constants.
    task automatic run(input int lim, input int ready_pct, input bit inject,
                       input int exp_count, input int exp_last);
        int  stream[$];
        int  model[$];
        int  cyc;
        int  held;
        int  unstable;
        int  lockstep;
        bit  stall;
        bit  seen_valid;
        int  n_exp;
        for (int n = 2; n <= lim; n++) begin
            if (is_prime(n)) model.push_back(n);
        end
        n_exp      = model.size();
        unstable   = 0;
        lockstep   = 0;
        stall      = 1'b0;
        seen_valid = 1'b0;
        held       = 0;

        @(negedge clk);
        limit     = ADDR_W'(lim);
        start     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        if (lim >= 2) begin
            check($sformatf("busy_after_start_%0d", lim), int'(a_busy), 1);
            check($sformatf("done_cleared_%0d", lim), int'(a_done), 0);
        end

        while (!a_done && cyc < BUDGET) begin
            if (a_valid) seen_valid = 1'b1;
            if (stall && (!a_valid || int'(a_data) != held)) unstable++;
            if (a_valid != b_valid || a_data != b_data) lockstep++;
            out_ready = ($urandom_range(99) < ready_pct);
            if (a_valid && out_ready) begin
                stream.push_back(int'(a_data));
                stall = 1'b0;
            end else if (a_valid) begin
                stall = 1'b1;
                held  = int'(a_data);
            end else begin
                stall = 1'b0;
            end
            if (inject && cyc == 12) begin
                start = 1'b1;
                limit = ADDR_W'(7);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;

        check($sformatf("timeout_%0d", lim), int'(a_done), 1);
        check($sformatf("busy_end_%0d", lim), int'(a_busy), 0);
        check($sformatf("count_%0d", lim), int'(a_cnt), n_exp);
        check($sformatf("overflow_%0d", lim), int'(a_ovf), 0);
        check($sformatf("stream_len_%0d", lim), stream.size(), n_exp);
        for (int i = 0; i < n_exp && i < stream.size(); i++) begin
            check($sformatf("stream_%0d_idx%0d", lim, i), stream[i], model[i]);
        end
        check($sformatf("stall_stable_%0d", lim), unstable, 0);
        check($sformatf("lockstep_%0d", lim), lockstep, 0);
        check($sformatf("count16_%0d", lim), int'(b_cnt), (n_exp > 16) ? 16 : n_exp);
        check($sformatf("overflow16_%0d", lim), int'(b_ovf), (n_exp > 16) ? 1 : 0);
        if (exp_count >= 0) begin
            check($sformatf("table_count_%0d", lim), int'(a_cnt), exp_count);
            check($sformatf("table_last_%0d", lim),
                  (stream.size() > 0) ? stream[stream.size()-1] : 0, exp_last);
        end
        if (lim < 2) begin
            check($sformatf("quick_done_%0d", lim), (cyc <= 2) ? 1 : 0, 1);
            check($sformatf("no_valid_%0d", lim), int'(seen_valid), 0);
        end
    endtask

    task automatic read_list(input int idx, input int exp_a, input int exp_b);
        @(negedge clk);
        rd_idx = IDX_W'(idx);
        @(negedge clk);
        check($sformatf("rd_data_idx%0d", idx), int'(a_rd), exp_a);
        check($sformatf("rd_data16_idx%0d", idx), int'(b_rd), exp_b);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{lim: 30,   ready_pct: 100, inject: 1'b1, exp_count: 10,  exp_last: 29};
        vecs[1] = '{lim: 1,    ready_pct: 100, inject: 1'b0, exp_count: 0,   exp_last: 0};
        vecs[2] = '{lim: 0,    ready_pct: 100, inject: 1'b0, exp_count: 0,   exp_last: 0};
        vecs[3] = '{lim: 2,    ready_pct: 100, inject: 1'b0, exp_count: 1,   exp_last: 2};
        vecs[4] = '{lim: 3,    ready_pct: 50,  inject: 1'b0, exp_count: 2,   exp_last: 3};
        vecs[5] = '{lim: 100,  ready_pct: 30,  inject: 1'b0, exp_count: 25,  exp_last: 97};
        vecs[6] = '{lim: 1023, ready_pct: 100, inject: 1'b0, exp_count: 172, exp_last: 1021};

        rst       = 1'b0;
        start     = 1'b0;
        limit     = '0;
        out_ready = 1'b0;
        rd_idx    = '0;
        repeat (3) @(negedge clk);
        check("reset_busy",     int'(a_busy),  0);
        check("reset_done",     int'(a_done),  0);
        check("reset_valid",    int'(a_valid), 0);
        check("reset_data",     int'(a_data),  0);
        check("reset_count",    int'(a_cnt),   0);
        check("reset_overflow", int'(a_ovf),   0);
        check("reset_rd_data",  int'(a_rd),    0);
        rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run(vecs[i].lim, vecs[i].ready_pct, vecs[i].inject,
                vecs[i].exp_count, vecs[i].exp_last);
        end

        // List contents after the full-range run.
        read_list(171, 1021, 0);
        read_list(200, 0, 0);
        read_list(15, 53, 53);
        read_list(16, 59, 0);
        read_list(0, 2, 2);

        for (int k = 0; k < 4; k++) begin
            run(int'($urandom_range(300, 2)), int'($urandom_range(90, 20)), 1'b0, -1, 0);
        end

        // Abort in the middle of marking, then a clean rerun.
        @(negedge clk);
        limit = ADDR_W'(500);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (520) @(negedge clk);
        check("abort_busy_before", int'(a_busy), 1);
        rst = 1'b0;
        #1;
        check("abort_busy",  int'(a_busy),  0);
        check("abort_done",  int'(a_done),  0);
        check("abort_valid", int'(a_valid), 0);
        check("abort_count", int'(a_cnt),   0);
        @(negedge clk);
        rst = 1'b1;
        run(30, 100, 1'b1, 10, 29);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
